multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock, rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port opcode  input  4  IR[15:12], stable from DECODE onward.
REQ-004 SHALL have port zero  input  1  ALU zero flag.
REQ-005 SHALL have port mem_ready  input  1  memory done; present only with MC_CTRL_MEM_WAIT_EN.
REQ-006 SHALL have outputs pc_we, ir_we, mem_re, mem_we, reg_we, alu_src_a, reg_dst, mem_to_reg, illegal_op  output  1 each  datapath strobes/selects.
REQ-007 SHALL have outputs alu_src_b, alu_op, pc_src  output  2 each  B-mux select (00 reg, 01 const 2, 10 imm, 11 imm<<1), ALU control class, PC mux (00 ALU, 01 ALUOut, 10 jump).
REQ-008 SHALL have port state  output  4  current state code, debug.

Function
REQ-009 SHALL implement Moore FSM: FETCH=0, DECODE=1, EXEC=2, ALU_WB=3, ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, JUMP=9.
REQ-010 SHALL go FETCH->DECODE; DECODE dispatches on opcode: 0000/0001/0010 (R) and 1001/1010/1011 (I) ->EXEC; 0100 (LW)/0101 (SW) ->ADDR; 0110 (BEQ) ->BRANCH; 1100 (J) ->JUMP; any other ->FETCH.
REQ-011 SHALL go EXEC->ALU_WB->FETCH; ADDR->MEM_RD (LW) or MEM_WR (SW); MEM_RD->MEM_WB->FETCH; MEM_WR, BRANCH, JUMP ->FETCH.
REQ-012 SHALL register in DECODE a class flag is_r (1 for R opcodes) used by EXEC/ALU_WB.
REQ-013 FETCH SHALL drive mem_re=1, ir_we=1, pc_we=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
REQ-014 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
REQ-015 EXEC SHALL drive alu_src_a=1, alu_src_b=is_r?00:10, alu_op=is_r?10:11.
REQ-016 ALU_WB SHALL drive reg_we=1, reg_dst=is_r, mem_to_reg=0.
REQ-017 ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00; MEM_RD mem_re=1; MEM_WB reg_we=1, mem_to_reg=1, reg_dst=0; MEM_WR mem_we=1.
REQ-018 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_we=zero.
REQ-019 JUMP SHALL drive pc_src=10, pc_we=1.
REQ-020 All outputs not listed for a state SHALL be 0.
REQ-021 illegal_op SHALL pulse 1 for exactly the DECODE cycle of an undefined opcode; no write strobe asserts for that instruction.
REQ-022 Latency (no wait) SHALL be R/I 4, LW 5, SW 4, BEQ 3, J 3 cycles, FETCH to next FETCH.

Reset
REQ-023 reset SHALL force state=FETCH and is_r=0 immediately, regardless of clk.
REQ-024 Reset mid-instruction SHALL abandon it; no strobe SHALL assert while reset is high except FETCH decodes, which are gated to 0 during reset.

Configuration
REQ-025 With MC_CTRL_MEM_WAIT_EN defined, FETCH, MEM_RD, MEM_WR SHALL hold until mem_ready=1, keeping mem_re/mem_we asserted; pc_we and ir_we in FETCH SHALL assert only in the cycle mem_ready=1.
REQ-026 Without MC_CTRL_MEM_WAIT_EN, mem_ready SHALL not exist and each memory state SHALL last one cycle.

Structure
REQ-027 Opcode constants, state encoding, alu_op and mux-select codes SHALL live in shared package cpu16_pkg.
REQ-028 Opcode classification (R/I/LW/SW/BEQ/J/illegal) SHALL be sub-module mc_ctrl_decode, combinational.

Verification
REQ-029 opcode=0001 after reset -> states 0,1,2,3,0; EXEC alu_op=10, alu_src_b=00; ALU_WB reg_we=1, reg_dst=1.
REQ-030 opcode=0100 -> states 0,1,4,5,6,0; MEM_WB reg_we=1, mem_to_reg=1.
REQ-031 opcode=0110 with zero=1 then zero=0 -> BRANCH pc_we=1 then 0, pc_src=01 both.
REQ-032 opcode=1111 -> illegal_op=1 one cycle in DECODE, next state FETCH, reg_we/mem_we never 1.
REQ-033 Macro on, mem_ready low 3 cycles in FETCH -> state 0 held 4 cycles, pc_we=1 only in the 4th.
REQ-034 reset pulse asserted mid-MEM_WR -> state=0 asynchronously, mem_we=0 same instant.

Source files
------------

// File: rtl/cpu16_pkg.sv
// Shared cpu16 definitions: opcodes, controller state codes, ALU and mux select codes,
// instruction classes and the control-strobe bundle driven by multicycle_ctrl.
package cpu16_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned ICLASS_W = 3;

  // Opcodes held in IR[15:12]
  localparam logic [OPCODE_W-1:0] OP_R0  = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_R1  = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_R2  = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_LW  = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_SW  = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_I0  = 4'b1001;
  localparam logic [OPCODE_W-1:0] OP_I1  = 4'b1010;
  localparam logic [OPCODE_W-1:0] OP_I2  = 4'b1011;
  localparam logic [OPCODE_W-1:0] OP_J   = 4'b1100;

  // ALU control classes
  localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALU_RTYPE = 2'b10;
  localparam logic [SEL_W-1:0] ALU_ITYPE = 2'b11;

  // ALU B-operand mux
  localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_TWO    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

  // PC source mux
  localparam logic [SEL_W-1:0] PC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC   = 4'd2,
    ST_ALU_WB = 4'd3,
    ST_ADDR   = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_MEM_WB = 4'd6,
    ST_MEM_WR = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9
  } state_e;

  typedef enum logic [ICLASS_W-1:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BEQ = 3'd4,
    CLS_J   = 3'd5,
    CLS_ILL = 3'd6
  } iclass_e;

  typedef struct packed {
    logic             pc_we;
    logic             ir_we;
    logic             mem_re;
    logic             mem_we;
    logic             reg_we;
    logic             alu_src_a;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             illegal_op;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] pc_src;
  } ctrl_t;

  // Map an opcode to its instruction class; anything unlisted is illegal
  function automatic iclass_e classify(input logic [OPCODE_W-1:0] op);
    iclass_e cls;
    cls = CLS_ILL;
    case (op)
      OP_R0, OP_R1, OP_R2: cls = CLS_R;
      OP_I0, OP_I1, OP_I2: cls = CLS_I;
      OP_LW:               cls = CLS_LW;
      OP_SW:               cls = CLS_SW;
      OP_BEQ:              cls = CLS_BEQ;
      OP_J:                cls = CLS_J;
      default:             cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode classifier for the multicycle controller.
module mc_ctrl_decode
  import cpu16_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] iclass_c
);

  assign iclass_c = ICLASS_W'(classify(opcode));

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the 16-bit multicycle datapath. Define MC_CTRL_MEM_WAIT_EN to add
// the mem_ready handshake that stretches FETCH, MEM_RD and MEM_WR.
module multicycle_ctrl
  import cpu16_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
`ifdef MC_CTRL_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_re,
  output logic       mem_we,
  output logic       reg_we,
  output logic       alu_src_a,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state
);

  state_e     state_q;
  state_e     state_d;
  logic       is_r_q;
  logic [2:0] iclass_raw;
  iclass_e    iclass;
  logic       mem_rdy;
  ctrl_t      ctrl;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  mc_ctrl_decode u_decode (
    .opcode   (opcode),
    .iclass_c (iclass_raw)
  );

  assign iclass = iclass_e'(iclass_raw);

  // State register; is_r is captured while the opcode is decoded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      is_r_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        is_r_q <= (iclass == CLS_R);
      end
    end
  end

  // Next state and Moore strobes; zero and mem_ready qualify strobes within a state
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_re    = 1'b1;
        ctrl.ir_we     = mem_rdy;
        ctrl.pc_we     = mem_rdy;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_TWO;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_ALU;
        if (mem_rdy) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
        case (iclass)
          CLS_R, CLS_I:   state_d = ST_EXEC;
          CLS_LW, CLS_SW: state_d = ST_ADDR;
          CLS_BEQ:        state_d = ST_BRANCH;
          CLS_J:          state_d = ST_JUMP;
          default: begin
            ctrl.illegal_op = 1'b1;
            state_d         = ST_FETCH;
          end
        endcase
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = is_r_q ? SRCB_REG : SRCB_IMM;
        ctrl.alu_op    = is_r_q ? ALU_RTYPE : ALU_ITYPE;
        state_d        = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.reg_dst    = is_r_q;
        ctrl.mem_to_reg = 1'b0;
        state_d         = ST_FETCH;
      end
      ST_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = (iclass == CLS_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        ctrl.mem_re = 1'b1;
        if (mem_rdy) begin
          state_d = ST_MEM_WB;
        end
      end
      ST_MEM_WB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
        state_d         = ST_FETCH;
      end
      ST_MEM_WR: begin
        ctrl.mem_we = 1'b1;
        if (mem_rdy) begin
          state_d = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_ALUOUT;
        ctrl.pc_we     = zero;
        state_d        = ST_FETCH;
      end
      ST_JUMP: begin
        ctrl.pc_src = PC_JUMP;
        ctrl.pc_we  = 1'b1;
        state_d     = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    // Reset parks the FSM in FETCH; its strobes must not reach the datapath meanwhile
    if (reset) begin
      ctrl = '0;
    end
  end

  assign pc_we      = ctrl.pc_we;
  assign ir_we      = ctrl.ir_we;
  assign mem_re     = ctrl.mem_re;
  assign mem_we     = ctrl.mem_we;
  assign reg_we     = ctrl.reg_we;
  assign alu_src_a  = ctrl.alu_src_a;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign illegal_op = ctrl.illegal_op;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against a per-instruction state-path and strobe-table model.
// Builds with or without MC_CTRL_MEM_WAIT_EN.
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       mr;
  logic       pc_we, ir_we, mem_re, mem_we, reg_we, alu_src_a, reg_dst, mem_to_reg, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  logic [18:0] obs;

  int vectors;
  int miscompares;
  int force_stall;
  logic [3:0] valid_ops [10];

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
`ifdef MC_CTRL_MEM_WAIT_EN
    .mem_ready  (mr),
`endif
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .reg_we     (reg_we),
    .alu_src_a  (alu_src_a),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal_op (illegal_op),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .state      (state)
  );

  assign obs = {pc_we, ir_we, mem_re, mem_we, reg_we, alu_src_a, reg_dst, mem_to_reg,
                illegal_op, alu_src_b, alu_op, pc_src, state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Strobe table per state, straight from the controller's output definitions
  function automatic logic [18:0] expect_vec(input int st, input bit r, input bit z,
                                             input bit ill, input bit rdy);
    bit pcw, irw, mre, mwe, rwe, sa, rd, m2r, il;
    bit [1:0] sb, aop, ps;
    {pcw, irw, mre, mwe, rwe, sa, rd, m2r, il} = '0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      0: begin mre = 1; irw = rdy; pcw = rdy; sb = 2'b01; end
      1: begin sb = 2'b11; il = ill; end
      2: begin sa = 1; sb = r ? 2'b00 : 2'b10; aop = r ? 2'b10 : 2'b11; end
      3: begin rwe = 1; rd = r; end
      4: begin sa = 1; sb = 2'b10; end
      5: mre = 1;
      6: begin rwe = 1; m2r = 1; end
      7: mwe = 1;
      8: begin sa = 1; aop = 2'b01; ps = 2'b01; pcw = z; end
      9: begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, irw, mre, mwe, rwe, sa, rd, m2r, il, sb, aop, ps, 4'(st)};
  endfunction

  // State visit list per instruction; its length is the instruction's latency
  function automatic void build_path(input logic [3:0] op, output int p[$]);
    case (op)
      4'b0000, 4'b0001, 4'b0010,
      4'b1001, 4'b1010, 4'b1011: p = '{0, 1, 2, 3};
      4'b0100:                   p = '{0, 1, 4, 5, 6};
      4'b0101:                   p = '{0, 1, 4, 7};
      4'b0110:                   p = '{0, 1, 8};
      4'b1100:                   p = '{0, 1, 9};
      default:                   p = '{0, 1};
    endcase
  endfunction

  function automatic bit is_mem_state(input int st);
    return (st == 0) || (st == 5) || (st == 7);
  endfunction

  // Pick mem_ready for this cycle; a forced stall or random low, capped so holds end
  function automatic bit pick_ready(input int st, input int held);
`ifdef MC_CTRL_MEM_WAIT_EN
    if (!is_mem_state(st)) return bit'($urandom_range(0, 1));
    if (held >= 5) return 1'b1;
    return bit'($urandom_range(0, 2) != 0);
`else
    return 1'b1;
`endif
  endfunction

  // Entered at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
  // zmode 0/1 fixes zero, 2 randomizes it each cycle. stop_at>=0 returns early on that state.
  task automatic run_instr(input logic [3:0] op, input int zmode, input int stop_at);
    int p[$];
    bit r, ill, held;
    int hold_cnt;
    build_path(op, p);
    r   = (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010);
    ill = (p.size() == 2);
    for (int i = 0; i < p.size(); i++) begin
      if (p[i] == stop_at) return;
      hold_cnt = 0;
      do begin
        opcode = op;
        zero   = (zmode == 2) ? bit'($urandom_range(0, 1)) : bit'(zmode);
        mr     = pick_ready(p[i], hold_cnt);
`ifdef MC_CTRL_MEM_WAIT_EN
        if (p[i] == 0 && force_stall > 0) begin
          mr = 1'b0;
          force_stall--;
        end
`endif
        #2;
        check($sformatf("op%h_st%0d", op, p[i]), obs,
              expect_vec(p[i], r, zero, ill && (p[i] == 1), mr));
        held = is_mem_state(p[i]) && !mr;
        hold_cnt++;
        @(negedge clk);
      end while (held);
    end
  endtask

  initial begin
    valid_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
                  4'b0110, 4'b1001, 4'b1010, 4'b1011, 4'b1100};
    vectors = 0; miscompares = 0; force_stall = 0;
    reset = 1'b1; opcode = 4'b0000; zero = 1'b0; mr = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_gated", obs, 19'h0);
    reset = 1'b0;

    // Directed: R, LW, BEQ taken/not taken, illegal, J, SW, I
    run_instr(4'b0001, 2, -1);
    run_instr(4'b0100, 2, -1);
    run_instr(4'b0110, 1, -1);
    run_instr(4'b0110, 0, -1);
    run_instr(4'b1111, 2, -1);
    run_instr(4'b1100, 2, -1);
    run_instr(4'b0101, 2, -1);
    run_instr(4'b1001, 2, -1);
`ifdef MC_CTRL_MEM_WAIT_EN
    force_stall = 3;
    run_instr(4'b0010, 2, -1);
`endif

    // Asynchronous reset in the middle of a store's memory write
    run_instr(4'b0101, 2, 7);
    opcode = 4'b0101; mr = 1'b0;
    #2 check("sw_mem_wr", obs, expect_vec(7, 0, zero, 0, 1'b0));
    #1 reset = 1'b1;
    #1 check("rst_async", obs, 19'h0);
    @(posedge clk); #1 check("rst_hold", obs, 19'h0);
    @(negedge clk); reset = 1'b0; mr = 1'b1;

    for (int n = 0; n < 150; n++) begin
      logic [3:0] op;
      if ($urandom_range(0, 3) == 0) op = 4'($urandom);
      else op = valid_ops[$urandom_range(0, 9)];
      run_instr(op, 2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
